// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single-port word memory.
// Define ARB_FAIR_EN for alternating priority under contention; default is data-over-fetch.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} own_t;
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mreq_t;

  state_t            state, state_nx;
  own_t              owner, owner_nx;
  mreq_t             mreq, mreq_nx;
  logic [DATA_W-1:0] resp, resp_nx;
  logic              pick_d;

`ifdef ARB_FAIR_EN
  own_t last, last_nx;
  // Contended grant goes to whichever port did not own the previous transaction.
  assign pick_d = d_req && (!i_req || (last == OWN_I));
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= OWN_I;
      mreq  <= '0;
      resp  <= '0;
`ifdef ARB_FAIR_EN
      last  <= OWN_I;
`endif
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      mreq  <= mreq_nx;
      resp  <= resp_nx;
`ifdef ARB_FAIR_EN
      last  <= last_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    mreq_nx  = mreq;
    resp_nx  = resp;
`ifdef ARB_FAIR_EN
    last_nx  = last;
`endif
    case (state)
      IDLE: begin
        if (pick_d) begin
          state_nx      = GNT_D;
          owner_nx      = OWN_D;
          mreq_nx.we    = d_we;
          mreq_nx.addr  = d_addr;
          mreq_nx.wdata = d_wdata;
        end else if (i_req) begin
          state_nx      = GNT_I;
          owner_nx      = OWN_I;
          mreq_nx.we    = 1'b0;
          mreq_nx.addr  = i_addr;
          mreq_nx.wdata = '0;
        end
`ifdef ARB_FAIR_EN
        if (pick_d || i_req) last_nx = owner_nx;
`endif
      end
      GNT_I, GNT_D: begin
        if (m_ready) begin
          resp_nx  = m_rdata;
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Everything below is decoded from registered state, so reset clears it at once.
  assign m_req   = (state == GNT_I) || (state == GNT_D);
  assign m_we    = mreq.we;
  assign m_addr  = mreq.addr;
  assign m_wdata = mreq.wdata;
  assign i_ack   = (state == RESP) && (owner == OWN_I);
  assign d_ack   = (state == RESP) && (owner == OWN_D);
  assign i_rdata = i_ack ? resp : '0;
  assign d_rdata = d_ack ? resp : '0;

  a_mreq_hold: assert property (@(posedge clock) disable iff (reset)
    (m_req && !m_ready) |=> (m_req && $stable(m_addr) && $stable(m_we) && $stable(m_wdata)));

endmodule
